// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: FSM state encoding and counter-width helper shared by the
// reset_sequencer sources.
package reset_seq_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_STRETCH = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    // Bits needed to hold counts 0..n-1, never fewer than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((longint'(1) << w) < longint'(n)) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/reset_sequencer_btn_debounce.sv
// btn_debounce: two-flop synchronizer followed by a debounce counter for an
// active-low push button. Output idles at 1 (released).
module btn_debounce
    import reset_seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din_n,
    output logic dout_n
);

    localparam int unsigned DB_W = cnt_width(DEBOUNCE_CYCLES);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_db;
    logic [DB_W-1:0] r_cnt;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= din_n;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_db  <= 1'b1;
            r_cnt <= '0;
        end else if (r_sync2 == r_db) begin
            r_cnt <= '0;
        end else if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            r_db  <= r_sync2;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign dout_n = r_db;

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: board-level reset tree. Debounces the user button,
// stretches every reset event, then releases NUM_STAGES outputs in order,
// STAGE_GAP cycles apart. Assertion is always simultaneous.
// Optional watchdog built when RESET_SEQ_WDT_EN is defined.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned STRETCH_CYCLES  = 1024,
    parameter int unsigned NUM_STAGES      = 3,
    parameter int unsigned STAGE_GAP       = 256,
    parameter int unsigned WDT_CYCLES      = 2**24
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  btn_n,
    input  logic                  wdt_kick,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  all_ready,
    output logic                  wdt_fired
);

    localparam int unsigned STR_W = cnt_width(STRETCH_CYCLES);
    localparam int unsigned GAP_W = cnt_width(STAGE_GAP);
    localparam int unsigned STG_W = cnt_width(NUM_STAGES);

    state_t                r_state;
    logic [STR_W-1:0]      r_stretch_cnt;
    logic [GAP_W-1:0]      r_gap_cnt;
    logic [STG_W-1:0]      r_stage;
    logic [NUM_STAGES-1:0] r_rst_out;
    logic                  r_all_ready;
    logic                  w_btn_db;
    logic                  w_wdt_expire;
    logic                  w_trig;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk    (clk),
        .reset_n(reset_n),
        .din_n  (btn_n),
        .dout_n (w_btn_db)
    );

    assign w_trig = !w_btn_db || w_wdt_expire;

    // Stretch / staged-release / run sequencing; any trigger re-asserts everything at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_STRETCH;
            r_stretch_cnt <= '0;
            r_gap_cnt     <= '0;
            r_stage       <= '0;
            r_rst_out     <= '1;
            r_all_ready   <= 1'b0;
        end else begin
            case (r_state)
                ST_STRETCH: begin
                    r_rst_out   <= '1;
                    r_all_ready <= 1'b0;
                    if (w_trig) begin
                        r_stretch_cnt <= '0;
                    end else if (r_stretch_cnt == STR_W'(STRETCH_CYCLES - 1)) begin
                        r_state       <= ST_RELEASE;
                        r_stretch_cnt <= '0;
                        r_stage       <= '0;
                        r_gap_cnt     <= '0;
                    end else begin
                        r_stretch_cnt <= r_stretch_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (w_trig) begin
                        r_state       <= ST_STRETCH;
                        r_stretch_cnt <= '0;
                        r_rst_out     <= '1;
                        r_all_ready   <= 1'b0;
                    end else if (r_gap_cnt == GAP_W'(STAGE_GAP - 1)) begin
                        r_rst_out[r_stage] <= 1'b0;
                        r_gap_cnt          <= '0;
                        if (r_stage == STG_W'(NUM_STAGES - 1)) begin
                            r_all_ready <= 1'b1;
                            r_state     <= ST_RUN;
                        end else begin
                            r_stage <= r_stage + 1'b1;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_trig) begin
                        r_state       <= ST_STRETCH;
                        r_stretch_cnt <= '0;
                        r_rst_out     <= '1;
                        r_all_ready   <= 1'b0;
                    end else begin
                        r_rst_out   <= '0;
                        r_all_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= ST_STRETCH;
                    r_stretch_cnt <= '0;
                    r_rst_out     <= '1;
                    r_all_ready   <= 1'b0;
                end
            endcase
        end
    end

    assign rst_out   = r_rst_out;
    assign all_ready = r_all_ready;

`ifdef RESET_SEQ_WDT_EN
    localparam int unsigned WDT_W = cnt_width(WDT_CYCLES);

    logic [WDT_W-1:0] r_wdt_cnt;
    logic             r_wdt_fired;

    // A kick in the terminal cycle suppresses expiry.
    assign w_wdt_expire = (r_state == ST_RUN) && !wdt_kick &&
                          (r_wdt_cnt == WDT_W'(WDT_CYCLES - 1));

    // Watchdog counts only while running; kicks and any non-RUN state restart it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wdt_cnt <= '0;
        end else if (r_state != ST_RUN || wdt_kick || w_wdt_expire) begin
            r_wdt_cnt <= '0;
        end else begin
            r_wdt_cnt <= r_wdt_cnt + 1'b1;
        end
    end

    // Sticky record of a watchdog-caused reset; only reset_n clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wdt_fired <= 1'b0;
        end else if (w_wdt_expire) begin
            r_wdt_fired <= 1'b1;
        end
    end

    assign wdt_fired = r_wdt_fired;
`else
    logic [1:0] w_unused_wdt;

    assign w_unused_wdt = {wdt_kick, WDT_CYCLES[0]};
    assign w_wdt_expire = 1'b0;
    assign wdt_fired    = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed, table-driven bench for reset_sequencer with
// DEBOUNCE_CYCLES=4, STRETCH_CYCLES=8, NUM_STAGES=3, STAGE_GAP=2, WDT_CYCLES=32.
`timescale 1ns/1ps
module tb_reset_sequencer;

    logic       clk;
    logic       reset_n;
    logic       btn_n;
    logic       wdt_kick;
    logic [2:0] rst_out;
    logic       all_ready;
    logic       wdt_fired;

    typedef struct {
        logic       btn_n;
        logic [2:0] rst;
        logic       rdy;
        logic       fired;
    } vec_t;

    vec_t vq[$];
    int   n_vec;
    int   n_miss;
    logic exp_sticky;

    reset_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .STRETCH_CYCLES (8),
        .NUM_STAGES     (3),
        .STAGE_GAP      (2),
        .WDT_CYCLES     (32)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .btn_n    (btn_n),
        .wdt_kick (wdt_kick),
        .rst_out  (rst_out),
        .all_ready(all_ready),
        .wdt_fired(wdt_fired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] r, input logic rd, input logic f);
        n_vec++;
        if (rst_out !== r || all_ready !== rd || wdt_fired !== f) begin
            n_miss++;
            $display("FAIL %s: got rst_out=%b all_ready=%b wdt_fired=%b, expected rst_out=%b all_ready=%b wdt_fired=%b",
                     name, rst_out, all_ready, wdt_fired, r, rd, f);
        end
    endtask

    task automatic add(input logic b, input logic [2:0] r, input logic rd, input logic f, input int n);
        for (int i = 0; i < n; i++) vq.push_back('{b, r, rd, f});
    endtask

    // Each record: drive btn_n, take one edge, compare outputs.
    task automatic run_table(input string name);
        foreach (vq[i]) begin
            btn_n = vq[i].btn_n;
            step();
            check($sformatf("%s[%0d]", name, i), vq[i].rst, vq[i].rdy, vq[i].fired);
        end
        vq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec    = 0;
        n_miss   = 0;
        reset_n  = 1'b0;
        btn_n    = 1'b1;
        wdt_kick = 1'b0;
        #12;
        check("reset_state", 3'b111, 1'b0, 1'b0);
        @(posedge clk);
        #3 reset_n = 1'b1;

        // Power-up: edges 1..9 all asserted, stages fall at 10, 12, 14.
        add(1'b1, 3'b111, 1'b0, 1'b0, 9);
        add(1'b1, 3'b110, 1'b0, 1'b0, 2);
        add(1'b1, 3'b100, 1'b0, 1'b0, 2);
        add(1'b1, 3'b000, 1'b1, 1'b0, 5);
        // Bounce: low 3 / high 1 / low 2 / high; never debounced.
        add(1'b0, 3'b000, 1'b1, 1'b0, 3);
        add(1'b1, 3'b000, 1'b1, 1'b0, 1);
        add(1'b0, 3'b000, 1'b1, 1'b0, 2);
        add(1'b1, 3'b000, 1'b1, 1'b0, 8);
        // Press held 20 cycles: assert at edge 7 after the fall.
        add(1'b0, 3'b000, 1'b1, 1'b0, 6);
        add(1'b0, 3'b111, 1'b0, 1'b0, 14);
        // Release: 6 debounce + 8 stretch + 6 stage edges.
        add(1'b1, 3'b111, 1'b0, 1'b0, 15);
        add(1'b1, 3'b110, 1'b0, 1'b0, 2);
        add(1'b1, 3'b100, 1'b0, 1'b0, 2);
        add(1'b1, 3'b000, 1'b1, 1'b0, 3);
        run_table("powerup_bounce_press");

        // Async reset pulse between edges while in RUN.
        @(posedge clk);
        #3 reset_n = 1'b0;
        #0.5;
        check("async_reset", 3'b111, 1'b0, 1'b0);
        #0.5 reset_n = 1'b1;

        // Press lands mid-release (while 3'b110): full re-assert and restretch.
        add(1'b1, 3'b111, 1'b0, 1'b0, 4);
        add(1'b0, 3'b111, 1'b0, 1'b0, 5);
        add(1'b0, 3'b110, 1'b0, 1'b0, 1);
        add(1'b0, 3'b111, 1'b0, 1'b0, 2);
        add(1'b1, 3'b111, 1'b0, 1'b0, 15);
        add(1'b1, 3'b110, 1'b0, 1'b0, 2);
        add(1'b1, 3'b100, 1'b0, 1'b0, 2);
        add(1'b1, 3'b000, 1'b1, 1'b0, 1);
        run_table("press_mid_release");

`ifdef RESET_SEQ_WDT_EN
        // One kick zeroes the count; no further kicks -> reset 32 edges later.
        wdt_kick = 1'b1;
        step();
        check("wdt_kick0", 3'b000, 1'b1, 1'b0);
        wdt_kick = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            step();
            check($sformatf("wdt_count[%0d]", i), 3'b000, 1'b1, 1'b0);
        end
        step();
        check("wdt_expire", 3'b111, 1'b0, 1'b1);
        add(1'b1, 3'b111, 1'b0, 1'b1, 9);
        add(1'b1, 3'b110, 1'b0, 1'b1, 2);
        add(1'b1, 3'b100, 1'b0, 1'b1, 2);
        add(1'b1, 3'b000, 1'b1, 1'b1, 2);
        run_table("wdt_rerelease");
        exp_sticky = 1'b1;
`else
        for (int i = 0; i < 40; i++) begin
            step();
            check($sformatf("no_wdt_idle[%0d]", i), 3'b000, 1'b1, 1'b0);
        end
        exp_sticky = 1'b0;
`endif

        // Regular kicks every 20 cycles keep the system running.
        for (int i = 0; i < 100; i++) begin
            wdt_kick = ((i % 20) == 0);
            step();
            check($sformatf("kick_run[%0d]", i), 3'b000, 1'b1, exp_sticky);
        end
        wdt_kick = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
